// File: rtl/nfc_stream_pkg.sv
// Shared definitions for the NAND read-data stream stages.
//   - state_t      : packer FSM encoding (IDLE/PACK/FLUSH/DRAIN)
//   - KEEP16_FULL  : both bytes of a 16-bit beat valid
//   - KEEP16_LOW   : only the low byte of a 16-bit beat valid
//   - LEN_WIDTH_DEFAULT : default width of byte-length fields
package nfc_stream_pkg;

  localparam int LEN_WIDTH_DEFAULT = 16;

  localparam logic [1:0] KEEP16_FULL = 2'b11;
  localparam logic [1:0] KEEP16_LOW  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/nfc_stream_out_reg.sv
// 32-bit registered stream output stage with valid/ready hold.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture load_* into the register (only when free)
//   load_data/keep/last : word to present downstream
//   m_ready         : downstream ready
//   m_valid/data/keep/last : registered stream output
//   free            : register can take a new word this cycle
module nfc_stream_out_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_keep,
  input  logic        load_last,
  input  logic        m_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        free
);

  // Empty, or the current word leaves on this edge.
  assign free = !m_valid || m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_ready) begin
      // Payload is left as-is; only valid drops after the handshake.
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nfc_rd_stream_packer.sv
// Packs the 16-bit NAND read stream into 32-bit little-endian words,
// enforces the expected transfer length and reports count/error/done.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, expected_bytes   : arm a transfer (IDLE only); 0 = no length check
//   s_valid/ready/data/keep/last : 16-bit input stream
//   m_valid/ready/data/keep/last : 32-bit output stream
//   busy          : not IDLE
//   done          : one-cycle completion pulse
//   byte_count    : bytes accepted this transfer (saturating)
//   length_error  : sticky length/keep error, cleared on start
module nfc_rd_stream_packer
  import nfc_stream_pkg::*;
#(
  parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] expected_bytes,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [15:0]          s_data,
  input  logic [1:0]           s_keep,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic [3:0]           m_keep,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] byte_count,
  output logic                 length_error
);

  state_t               state;
  logic [LEN_WIDTH-1:0] exp_len;
  logic [15:0]          hold;
  logic                 hold_valid;
  logic                 input_ended;

  logic                 out_free;
  logic                 accept;
  logic [1:0]           beat_bytes;
  logic                 bad_keep;
  logic [LEN_WIDTH:0]   sum;
  logic [LEN_WIDTH-1:0] next_count;
  logic                 reach;
  logic                 final_beat;
  logic                 emit;
  logic                 load;
  logic [31:0]          word_data;
  logic [3:0]           word_keep;

  // Ready in PACK follows only the output register, never the input beat.
  assign s_ready = ((state == ST_PACK) && out_free) || (state == ST_DRAIN);
  assign accept  = s_valid && s_ready;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    beat_bytes = 2'd0;
    bad_keep   = 1'b0;
    word_data  = '0;
    word_keep  = '0;
    emit       = 1'b0;

    case (s_keep)
      2'b00:      beat_bytes = 2'd0;
      KEEP16_LOW: begin
        // A single trailing byte is only legal on the last beat.
        beat_bytes = s_last ? 2'd1 : 2'd2;
        bad_keep   = !s_last;
      end
      default: begin
        beat_bytes = 2'd2;
        bad_keep   = (s_keep != KEEP16_FULL);
      end
    endcase

    sum        = {1'b0, byte_count} + (LEN_WIDTH+1)'(beat_bytes);
    next_count = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    // Count may step past an odd expected length, hence >=.
    reach      = (exp_len != '0) && (next_count >= exp_len);
    final_beat = s_last || reach;

    if (beat_bytes == 2'd1) begin
      emit = 1'b1;
      if (hold_valid) begin
        word_data = {8'h00, s_data[7:0], hold};
        word_keep = 4'b0111;
      end else begin
        word_data = {24'h0, s_data[7:0]};
        word_keep = 4'b0001;
      end
    end else if (beat_bytes == 2'd2) begin
      if (hold_valid) begin
        emit      = 1'b1;
        word_data = {s_data, hold};
        word_keep = 4'b1111;
      end else if (final_beat) begin
        emit      = 1'b1;
        word_data = {16'h0, s_data};
        word_keep = 4'b0011;
      end
    end else if (final_beat) begin
      // Empty last beat: flush whatever is held (possibly nothing).
      emit = 1'b1;
      if (hold_valid) begin
        word_data = {16'h0, hold};
        word_keep = 4'b0011;
      end
    end

    load = (state == ST_PACK) && accept && emit;
  end

  nfc_stream_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (word_data),
    .load_keep (word_keep),
    .load_last (final_beat),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .free      (out_free)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      exp_len      <= '0;
      // NOTE: the holding register data is reset too, not only its valid
      // flag, so no stale half-word can ever be observed after reset.
      hold         <= '0;
      hold_valid   <= 1'b0;
      input_ended  <= 1'b0;
      byte_count   <= '0;
      length_error <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_len      <= expected_bytes;
            byte_count   <= '0;
            length_error <= 1'b0;
            hold_valid   <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (accept) begin
            byte_count <= next_count;
            if (bad_keep) length_error <= 1'b1;
            if (final_beat) begin
              // Short: last before the expected length. Long: length met
              // while the source still has beats to send.
              if (s_last && (exp_len != '0) && (next_count < exp_len))
                length_error <= 1'b1;
              if (reach && !s_last)
                length_error <= 1'b1;
              hold_valid  <= 1'b0;
              input_ended <= s_last;
              state       <= ST_FLUSH;
            end else if (beat_bytes == 2'd2) begin
              if (hold_valid) begin
                hold_valid <= 1'b0;
              end else begin
                hold       <= s_data;
                hold_valid <= 1'b1;
              end
            end
          end
        end
        ST_FLUSH: begin
          // Only the final word can be in the output register here.
          if (m_valid && m_ready) begin
            if (input_ended) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && s_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nfc_rd_stream_packer.md
Name: nfc_rd_stream_packer

Overview:
- Consumes the 16-bit read-data stream produced by the NAND physical input stage (valid/ready, 2-bit keep, last).
- Packs pairs of half-words into 32-bit little-endian words for the DMA/host-side FIFO.
- Enforces the expected page/chunk byte length, terminates or drains on mismatch, and reports byte count, error and a done pulse to the command sequencer.

Parameters:
- LEN_WIDTH, 16, width of iExpectedBytes and oByteCount.

Ports:
- iSystemClock  in  1  single clock for all logic.
- iModuleReset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse that arms a transfer; ignored unless in IDLE.
- iExpectedBytes  in  LEN_WIDTH  byte length, sampled on iStart; 0 = no length check.
- iS_Valid  in  1  input beat valid.
- oS_Ready  out  1  input beat accepted when iS_Valid && oS_Ready.
- iS_Data  in  16  input half-word; byte0 = [7:0], byte1 = [15:8].
- iS_Keep  in  2  byte enables of the input beat.
- iS_Last  in  1  final input beat.
- oM_Valid  out  1  output word valid.
- iM_Ready  in  1  downstream ready.
- oM_Data  out  32  packed word, little-endian.
- oM_Keep  out  4  byte enables of the output word.
- oM_Last  out  1  final output word.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle pulse at transfer completion.
- oByteCount  out  LEN_WIDTH  bytes accepted this transfer; held after done until the next iStart.
- oLengthError  out  1  sticky error flag; cleared on iStart.

Behaviour:
- Reset (synchronous, active-high), applied in any state including mid-transfer:
  - state returns to IDLE;
  - oM_Valid, oM_Last, oDone, oBusy, oLengthError and oS_Ready are 0;
  - oM_Data, oM_Keep and oByteCount are 0;
  - the half-word holding register is emptied.
- FSM states: IDLE, PACK, FLUSH, DRAIN.
- IDLE:
  - oS_Ready = 0.
  - On iStart: latch the length, clear the count and error, go to PACK.
- PACK:
  - oS_Ready = !oM_Valid || iM_Ready. This depends combinationally on iM_Ready only, never on iS_*.
  - Accepted beat with iS_Keep = 00: no data, no count change. If iS_Last is also set, the pending half-word (if any) is emitted as the final word.
  - Accepted beat with iS_Keep = 11: add 2 to the count.
    - If the holding register is empty: store the beat as the low half.
    - Otherwise: emit {iS_Data, hold} with oM_Keep = 1111.
  - Accepted beat with iS_Keep = 01: legal only together with iS_Last. Add 1 to the count and emit the final word: keep 0001 (nothing held) or 0111 (low half held). Upper bytes of oM_Data are 0.
  - Accepted beat with iS_Keep = 01 without iS_Last, or with iS_Keep = 10: set oLengthError and treat the beat as 11.
  - Latency: the output word is registered and oM_Valid rises the cycle after the completing input beat is accepted.
  - Final word condition: iS_Last is accepted, OR the count reaches a nonzero iExpectedBytes. Effect:
    - emit the final word with oM_Last = 1, flushing any held half (keep 0011);
    - go to FLUSH;
    - record in rInputEnded whether iS_Last was seen.
  - iS_Last with count < nonzero expected: set oLengthError (short transfer).
  - Count reaching expected without iS_Last: set oLengthError (long transfer).
  - Count reaching expected and iS_Last on the same beat: no error.
- Output handshake: oM_Data, oM_Keep and oM_Last are held stable while oM_Valid && !iM_Ready. oM_Valid clears on handshake unless a new word is loaded in the same cycle.
- FLUSH:
  - oS_Ready = 0.
  - On the final-word handshake: if rInputEnded, pulse oDone and go to IDLE; otherwise go to DRAIN.
- DRAIN:
  - oS_Ready = 1; beats are discarded and not counted.
  - On accepted iS_Last: pulse oDone and go to IDLE.
- Counter: saturates at all-ones; no wrap.
- iStart outside IDLE: ignored.

Decomposition:
- Shared package nfc_stream_pkg:
  - state encoding (IDLE/PACK/FLUSH/DRAIN);
  - keep constants KEEP16_FULL = 11 and KEEP16_LOW = 01;
  - LEN_WIDTH default.
- One sub-module, nfc_stream_out_reg: the 32-bit output register with valid/ready hold logic, reusable by other stream stages.

Test Plan:
- Nominal:
  - Stimulus: expected = 8; beats 0x0201, 0x0403, 0x0605, 0x0807 with keep 11, last on the 4th; iM_Ready = 1.
  - Response: words 0x04030201 and 0x08070605, keep F; oM_Last on the second word; oDone once; count 8; error 0.
- Odd length:
  - Stimulus: expected = 5; beats 0x0201, 0x0403, 0xAA05 with keep 01 and last.
  - Response: 0x04030201 keep F, then 0x00000005 keep 1 with last; count 5; no error.
- Backpressure:
  - Stimulus: nominal transfer with iM_Ready low for 3 cycles while oM_Valid = 1.
  - Response: oS_Ready low, oM_Data held at 0x04030201, no beats lost or duplicated.
- Short transfer:
  - Stimulus: expected = 8; last on the 2nd beat.
  - Response: word 0x04030201 with last; oLengthError = 1; count 4; oDone.
- Long transfer:
  - Stimulus: expected = 4; six beats, last on the 6th.
  - Response: single word 0x04030201 with last; FSM in DRAIN absorbs 4 beats; oDone at the 6th beat; error = 1; count 4.
- Reset mid-transfer:
  - Stimulus: assert iModuleReset after 1 beat with a half-word held, then start a nominal transfer.
  - Response: all outputs 0 the next cycle; the following transfer produces clean words with no stale half.
